riscv_mem_bus: RTL and testbench

Unified memory and memory-mapped I/O slave sitting directly downstream of the multicycle RISC-V core's single memory port. Serves instruction fetches, loads and byte-masked stores to an on-chip RAM, and decodes a small I/O window holding an LED register, a free-running cycle counter and a FIFO-buffered 8N1 UART transmitter. Read data is registered with a fixed one-cycle latency, matching the core's FETCH→WAIT and LOAD→WAIT_DATA state pairs.

---
 rtl/mem_bus_pkg.sv | 28 ++
 rtl/mem_bus_uart_tx.sv | 151 +++++++++++++++
 rtl/riscv_mem_bus.sv | 135 +++++++++++++
 tb/tb_riscv_mem_bus.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_pkg.sv
// rtl/mem_bus_pkg.sv - shared constants, register map and UART state type for riscv_mem_bus
package mem_bus_pkg;

    localparam logic [31:0] IO_BASE = 32'h8000_0000;

    localparam logic [1:0] REG_LED         = 2'd0;
    localparam logic [1:0] REG_UART_DATA   = 2'd1;
    localparam logic [1:0] REG_UART_STATUS = 2'd2;
    localparam logic [1:0] REG_CYCLE       = 2'd3;

    localparam int STAT_FULL    = 0;
    localparam int STAT_BUSY    = 1;
    localparam int STAT_OVF     = 2;
    localparam int STAT_CNT_LSB = 4;

    typedef enum logic [1:0] {
        UART_IDLE  = 2'd0,
        UART_START = 2'd1,
        UART_DATA  = 2'd2,
        UART_STOP  = 2'd3
    } uart_state_t;

    // FIFO occupancy is reported in a 4-bit field, so larger counts clamp at 15
    function automatic logic [3:0] sat_count(input logic [31:0] cnt);
        return (cnt > 32'd15) ? 4'hF : cnt[3:0];
    endfunction

endpackage

// File: rtl/mem_bus_uart_tx.sv
// rtl/mem_bus_uart_tx.sv - byte FIFO feeding an 8N1 serializer with registered line output
module mem_bus_uart_tx
    import mem_bus_pkg::*;
#(
    parameter int CLK_DIV    = 868,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          push,
    input  logic [7:0]                    data,
    input  logic                          ovf_clr,
    output logic                          full,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          overflow,
    output logic                          busy,
    output logic                          tx
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int BW = $clog2(CLK_DIV);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLK_DIV - 1);
    localparam logic [AW:0]   DEPTH_C   = (AW + 1)'(FIFO_DEPTH);

    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    uart_state_t   state;
    uart_state_t   state_next;
    logic [BW-1:0] baud_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shifter;
    logic          empty;
    logic          bit_done;
    logic          pop;
    logic          push_ok;
    logic          tx_next;

    assign empty    = (count == '0);
    assign full     = (count == DEPTH_C);
    assign bit_done = (baud_cnt == BAUD_LAST);
    // a push into a full FIFO still lands when the serializer pops the same cycle
    assign push_ok  = push && (!full || pop);

    // FIFO storage, not reset
    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_mem[wr_ptr] <= data;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // sticky overflow: set on a dropped byte, cleared by a STATUS write
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow <= 1'b0;
        end else if (push && full && !pop) begin
            overflow <= 1'b1;
        end else if (ovf_clr) begin
            overflow <= 1'b0;
        end
    end

    // serializer state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= UART_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // serializer next-state: STOP chains straight into START when more bytes wait
    always_comb begin
        state_next = state;
        case (state)
            UART_IDLE:  if (!empty) state_next = UART_START;
            UART_START: if (bit_done) state_next = UART_DATA;
            UART_DATA:  if (bit_done && bit_idx == 3'd7) state_next = UART_STOP;
            UART_STOP:  if (bit_done) state_next = empty ? UART_IDLE : UART_START;
            default:    state_next = UART_IDLE;
        endcase
    end

    // serializer outputs: FIFO pop strobe, busy flag and next line level
    always_comb begin
        pop     = 1'b0;
        tx_next = 1'b1;
        busy    = (state != UART_IDLE);
        case (state)
            UART_IDLE:  pop = !empty;
            UART_START: tx_next = 1'b0;
            UART_DATA:  tx_next = shifter[0];
            UART_STOP:  pop = bit_done && !empty;
            default:    tx_next = 1'b1;
        endcase
    end

    // bit timing, bit index and shift register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            shifter  <= '0;
        end else begin
            baud_cnt <= (state == UART_IDLE || bit_done) ? '0 : baud_cnt + 1'b1;
            if (state == UART_DATA) begin
                if (bit_done) begin
                    bit_idx <= bit_idx + 3'd1;
                end
            end else begin
                bit_idx <= '0;
            end
            if (pop) begin
                shifter <= fifo_mem[rd_ptr];
            end else if (state == UART_DATA && bit_done) begin
                shifter <= {1'b0, shifter[7:1]};
            end
        end
    end

    // registered line output so the pin is glitch-free; reset forces idle-high
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx <= 1'b1;
        end else begin
            tx <= tx_next;
        end
    end

endmodule

// File: rtl/riscv_mem_bus.sv
// rtl/riscv_mem_bus.sv - RAM plus LED/CYCLE/UART I/O slave for the core memory port; UART built when MEM_BUS_UART_EN is defined
module riscv_mem_bus
    import mem_bus_pkg::*;
#(
    parameter int    RAM_WORDS  = 1024,
    parameter string INIT_FILE  = "firmware.hex",
    parameter int    CLK_DIV    = 868,
    parameter int    FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] Address,
    input  logic [31:0] WriteData,
    input  logic        MemWrite,
    input  logic [3:0]  WriteMask,
    output logic [31:0] ReadData,
    output logic [7:0]  leds,
    output logic        uart_tx
);

    localparam int AW = $clog2(RAM_WORDS);

    logic [31:0]   ram [RAM_WORDS];
    logic [31:0]   ram_q;
    logic [31:0]   io_q;
    logic          ram_sel_q;
    logic [31:0]   cycle;
    logic [31:0]   io_rdata;
    logic [31:0]   status_word;
    logic [AW-1:0] word_idx;
    logic [1:0]    reg_off;
    logic          io_sel;
    logic          wr_en;
    logic          ram_we;
    logic          io_we;
    logic          led_we;
    logic          unused_addr_bits;

    assign io_sel   = (Address[31] == IO_BASE[31]);
    assign word_idx = Address[AW+1:2];
    assign reg_off  = Address[3:2];
    assign wr_en    = MemWrite && (|WriteMask);
    assign ram_we   = wr_en && !io_sel;
    assign io_we    = wr_en && io_sel;
    assign led_we   = io_we && (reg_off == REG_LED) && WriteMask[0];

    // upper RAM bits alias and the I/O window only decodes [3:2]
    assign unused_addr_bits = ^{Address[30:4], Address[1:0]};

    // RAM lane writes and synchronous read; a same-cycle read sees the old word
    always_ff @(posedge clk) begin
        if (ram_we) begin
            for (int i = 0; i < 4; i++) begin
                if (WriteMask[i]) begin
                    ram[word_idx][8*i +: 8] <= WriteData[8*i +: 8];
                end
            end
        end
        ram_q <= ram[word_idx];
    end

`ifdef MEM_BUS_UART_EN
    logic                        uart_push;
    logic                        status_we;
    logic                        uart_full;
    logic                        uart_busy;
    logic                        uart_ovf;
    logic [$clog2(FIFO_DEPTH):0] uart_count;

    assign uart_push = io_we && (reg_off == REG_UART_DATA) && WriteMask[0];
    assign status_we = io_we && (reg_off == REG_UART_STATUS);

    mem_bus_uart_tx #(
        .CLK_DIV    (CLK_DIV),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_uart_tx (
        .clk      (clk),
        .reset_n  (reset_n),
        .push     (uart_push),
        .data     (WriteData[7:0]),
        .ovf_clr  (status_we),
        .full     (uart_full),
        .count    (uart_count),
        .overflow (uart_ovf),
        .busy     (uart_busy),
        .tx       (uart_tx)
    );

    // pack UART flags into the STATUS layout
    always_comb begin
        status_word                        = '0;
        status_word[STAT_FULL]             = uart_full;
        status_word[STAT_BUSY]             = uart_busy;
        status_word[STAT_OVF]              = uart_ovf;
        status_word[STAT_CNT_LSB +: 4]     = sat_count(32'(uart_count));
    end
`else
    localparam int unused_uart_cfg = CLK_DIV + FIFO_DEPTH;

    assign uart_tx     = 1'b1;
    assign status_word = '0;
`endif

    // I/O read mux for the register addressed this cycle
    always_comb begin
        io_rdata = '0;
        case (reg_off)
            REG_LED:         io_rdata = {24'b0, leds};
            REG_UART_DATA:   io_rdata = '0;
            REG_UART_STATUS: io_rdata = status_word;
            REG_CYCLE:       io_rdata = cycle;
            default:         io_rdata = '0;
        endcase
    end

    // LED register, free-running cycle counter and registered I/O read path
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            leds      <= '0;
            cycle     <= '0;
            io_q      <= '0;
            ram_sel_q <= 1'b0;
        end else begin
            cycle     <= cycle + 32'd1;
            io_q      <= io_rdata;
            ram_sel_q <= !io_sel;
            if (led_we) begin
                leds <= WriteData[7:0];
            end
        end
    end

    assign ReadData = ram_sel_q ? ram_q : io_q;

endmodule

// File: tb/tb_riscv_mem_bus.sv
// tb/tb_riscv_mem_bus.sv - randomized and directed self-checking bench for riscv_mem_bus
module tb_riscv_mem_bus;

    localparam int CLK_DIV    = 4;
    localparam int FIFO_DEPTH = 8;
    localparam int RAM_WORDS  = 256;
    localparam int FRAME      = 10 * CLK_DIV;

    localparam logic [31:0] A_LED  = 32'h8000_0000;
    localparam logic [31:0] A_DATA = 32'h8000_0004;
    localparam logic [31:0] A_STAT = 32'h8000_0008;
    localparam logic [31:0] A_CYC  = 32'h8000_000C;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] Address;
    logic [31:0] WriteData;
    logic        MemWrite;
    logic [3:0]  WriteMask;
    logic [31:0] ReadData;
    logic [7:0]  leds;
    logic        uart_tx;

    riscv_mem_bus #(
        .RAM_WORDS  (RAM_WORDS),
        .INIT_FILE  (""),
        .CLK_DIV    (CLK_DIV),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .Address   (Address),
        .WriteData (WriteData),
        .MemWrite  (MemWrite),
        .WriteMask (WriteMask),
        .ReadData  (ReadData),
        .leds      (leds),
        .uart_tx   (uart_tx)
    );

    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          tb_cyc  = 0;
    logic [31:0] mem_m [RAM_WORDS];
    logic [7:0]  led_m;
    logic [7:0]  rx_q [$];
    int          rx_t [$];
    bit          rx_en = 1'b0;

    // clocks since reset release: the CYCLE register must equal this after each edge
    always @(posedge clk) begin
        if (reset_n === 1'b1) tb_cyc = tb_cyc + 1;
        else                  tb_cyc = 0;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic bus(input logic [31:0] a, input logic [31:0] wd, input logic we, input logic [3:0] m);
        @(negedge clk);
        Address   = a;
        WriteData = wd;
        MemWrite  = we;
        WriteMask = m;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) bus(32'h0, 32'h0, 1'b0, 4'h0);
    endtask

    function automatic logic [31:0] ram_addr(input int idx);
        logic [31:0] a;
        a = $urandom & 32'h7FFF_FFFF;
        a = a & ~(32'(RAM_WORDS - 1) << 2);
        return a | (32'(idx) << 2);
    endfunction

    function automatic logic [31:0] io_addr(input int off);
        return 32'h8000_0000 | ($urandom & 32'h7FFF_FFF0) | (32'(off) << 2) | ($urandom & 32'h3);
    endfunction

    function automatic int model_idx(input logic [31:0] a);
        return int'((a >> 2) % RAM_WORDS);
    endfunction

    // frame bit n of an 8N1 frame: start, eight data bits LSB first, stop
    function automatic logic frame_bit(input logic [7:0] d, input int n);
        if (n == 0) return 1'b0;
        if (n == 9) return 1'b1;
        return d[n-1];
    endfunction

    // behavioural 8N1 receiver sampling mid-bit on the bench clock
    initial begin : rx_mon
        int       off;
        int       start_cyc;
        bit       abort;
        logic [7:0] b;
        forever begin
            @(posedge clk);
            #2;
            if (rx_en && reset_n === 1'b1 && uart_tx === 1'b0) begin
                start_cyc = tb_cyc;
                off   = 0;
                abort = 1'b0;
                b     = 8'h00;
                for (int n = 0; n < 10; n++) begin
                    while (off < n * CLK_DIV + CLK_DIV / 2) begin
                        @(posedge clk);
                        #2;
                        off++;
                        if (reset_n !== 1'b1) abort = 1'b1;
                    end
                    if (!abort) begin
                        if (n == 0)      check("rx_start_bit", 32'(uart_tx), 32'h0);
                        else if (n == 9) check("rx_stop_bit", 32'(uart_tx), 32'h1);
                        else             b[n-1] = uart_tx;
                    end
                end
                while (off < FRAME - 1) begin
                    @(posedge clk);
                    #2;
                    off++;
                end
                if (!abort) begin
                    rx_q.push_back(b);
                    rx_t.push_back(start_cyc);
                end
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: time limit reached, tests=%0d", n_tests);
        $fatal(1, "watchdog");
    end

    initial begin : main
        int          pool [32];
        int          op;
        int          idx;
        int          mi;
        int          cnt;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] old;
        logic [31:0] c1;
        logic [31:0] c2;
        logic [3:0]  m;
        logic        we;
        logic [7:0]  pb [10];
        logic [7:0]  extra;

        reset_n   = 1'b0;
        Address   = '0;
        WriteData = '0;
        MemWrite  = 1'b0;
        WriteMask = '0;
        led_m     = 8'h00;

        repeat (3) @(posedge clk);
        #1;
        check("reset_readdata", ReadData, 32'h0);
        check("reset_leds", 32'(leds), 32'h0);
        check("reset_uart_tx", 32'(uart_tx), 32'h1);
        @(negedge clk);
        reset_n = 1'b1;

        bus(A_CYC, 32'h0, 1'b0, 4'h0);
        check("cycle_after_reset", ReadData, 32'(tb_cyc - 1));
        bus(A_STAT, 32'h0, 1'b0, 4'h0);
        check("status_after_reset", ReadData, 32'h0);
        bus(A_LED, 32'h0, 1'b0, 4'h0);
        check("led_read_after_reset", ReadData, 32'h0);

        // byte-masked store then read
        bus(32'h0000_0100, 32'hDEAD_BEEF, 1'b1, 4'b1111);
        bus(32'h0000_0100, 32'h0000_5500, 1'b1, 4'b0010);
        bus(32'h0000_0100, 32'h0, 1'b0, 4'h0);
        check("ram_masked_store", ReadData, 32'hDEAD_55EF);
        mem_m[64] = 32'hDEAD_55EF;

        // LED write and read back
        bus(A_LED, 32'h1234_56A5, 1'b1, 4'b0001);
        led_m = 8'hA5;
        check("leds_pin_a5", 32'(leds), 32'hA5);
        bus(A_LED, 32'h0, 1'b0, 4'h0);
        check("led_read_a5", ReadData, 32'h0000_00A5);

        // known contents for a pool of words at both ends of RAM
        for (int i = 0; i < 32; i++) begin
            pool[i] = (i < 16) ? i : RAM_WORDS - 32 + i;
            wd = $urandom;
            a  = ram_addr(pool[i]);
            bus(a, wd, 1'b1, 4'hF);
            mem_m[model_idx(a)] = wd;
        end

        // randomized mix of RAM and register traffic
        for (int it = 0; it < 300; it++) begin
            op  = $urandom_range(0, 10);
            idx = pool[$urandom_range(0, 31)];
            a   = ram_addr(idx);
            mi  = model_idx(a);
            wd  = $urandom;
            m   = 4'($urandom);
            case (op)
                0, 1, 2: begin
                    old = mem_m[mi];
                    bus(a, wd, 1'b1, m);
                    check("ram_write_old_data", ReadData, old);
                    for (int l = 0; l < 4; l++)
                        if (m[l]) mem_m[mi][8*l +: 8] = wd[8*l +: 8];
                end
                3: begin
                    bus(a, wd, 1'b0, m);
                    check("ram_read_no_strobe", ReadData, mem_m[mi]);
                end
                4: begin
                    bus(a, wd, 1'b1, 4'h0);
                    check("ram_write_zero_mask", ReadData, mem_m[mi]);
                end
                5: begin
                    bus(a, 32'h0, 1'b0, 4'h0);
                    check("ram_read", ReadData, mem_m[mi]);
                end
                6: begin
                    old = {24'h0, led_m};
                    bus(io_addr(0), wd, 1'b1, m);
                    check("led_write_old_data", ReadData, old);
                    if (m[0]) led_m = wd[7:0];
                    check("leds_pin", 32'(leds), 32'(led_m));
                end
                7: begin
                    bus(io_addr(0), 32'h0, 1'b0, 4'h0);
                    check("led_read", ReadData, {24'h0, led_m});
                end
                8: begin
                    we = 1'($urandom);
                    bus(io_addr(3), wd, we, m);
                    check("cycle_read", ReadData, 32'(tb_cyc - 1));
                end
                9: begin
                    bus(io_addr(1), wd, 1'b0, m);
                    check("data_reg_reads_zero", ReadData, 32'h0);
                end
                default: begin
                    bus(io_addr(2), wd, 1'b1, 4'($urandom_range(1, 15)));
                    check("status_idle", ReadData, 32'h0);
                end
            endcase
        end

        // CYCLE sampled twice, five clocks apart
        bus(A_CYC, 32'h0, 1'b0, 4'h0);
        c1 = ReadData;
        idle(4);
        bus(A_CYC, 32'h0, 1'b0, 4'h0);
        c2 = ReadData;
        check("cycle_delta_5", c2 - c1, 32'd5);

`ifdef MEM_BUS_UART_EN
        // single frame: line timing and busy duration
        rx_q.delete();
        rx_t.delete();
        rx_en = 1'b1;
        bus(A_DATA, 32'h0000_0055, 1'b1, 4'b0001);
        cnt = 0;
        for (int k = 1; k <= FRAME + 5; k++) begin
            bus(A_STAT, 32'h0, 1'b0, 4'h0);
            if (k >= 2 && k <= FRAME + 1)
                check($sformatf("tx55_k%0d", k), 32'(uart_tx), 32'(frame_bit(8'h55, (k - 2) / CLK_DIV)));
            else
                check($sformatf("tx55_idle_k%0d", k), 32'(uart_tx), 32'h1);
            if (ReadData[1]) cnt++;
        end
        check("busy_cycles", 32'(cnt), 32'(FRAME));
        check("rx55_count", 32'(rx_q.size()), 32'd1);
        if (rx_q.size() > 0) check("rx55_byte", 32'(rx_q[0]), 32'h55);

        // burst of ten pushes into an eight-deep FIFO
        rx_q.delete();
        rx_t.delete();
        for (int i = 0; i < 10; i++) begin
            pb[i] = 8'($urandom);
            bus(A_DATA, {24'($urandom), pb[i]}, 1'b1, 4'b0001);
        end
        bus(A_STAT, 32'h0, 1'b0, 4'h0);
        check("status_after_burst", ReadData, 32'h87);
        bus(A_STAT, $urandom, 1'b1, 4'($urandom_range(1, 15)));
        bus(A_STAT, 32'h0, 1'b0, 4'h0);
        check("status_ovf_cleared", ReadData, 32'h83);
        // first frame ends 40 clocks after its pop; push exactly on that edge
        idle(FRAME - 12);
        extra = 8'($urandom);
        bus(A_DATA, {24'h0, extra}, 1'b1, 4'b0001);
        bus(A_STAT, 32'h0, 1'b0, 4'h0);
        check("status_push_pop_full", ReadData, 32'h83);
        for (int k = 0; k < 12 * FRAME && rx_q.size() < 10; k++) idle(1);
        check("rx_burst_count", 32'(rx_q.size()), 32'd10);
        if (rx_q.size() == 10) begin
            for (int i = 0; i < 9; i++) check($sformatf("rx_burst_byte%0d", i), 32'(rx_q[i]), 32'(pb[i]));
            check("rx_burst_extra", 32'(rx_q[9]), 32'(extra));
            for (int i = 0; i < 9; i++) check($sformatf("rx_gap%0d", i), 32'(rx_t[i+1] - rx_t[i]), 32'(FRAME));
        end
        idle(5);
        bus(A_STAT, 32'h0, 1'b0, 4'h0);
        check("status_drained", ReadData, 32'h0);
        rx_en = 1'b0;
`else
        // no UART: pushes are ignored and the line stays idle
        bus(A_DATA, 32'h0000_0041, 1'b1, 4'b0001);
        cnt = 0;
        for (int k = 0; k < 20; k++) begin
            bus(A_STAT, 32'h0, 1'b0, 4'h0);
            if (uart_tx !== 1'b1) cnt++;
            check("status_no_uart", ReadData, 32'h0);
        end
        check("tx_low_no_uart", 32'(cnt), 32'h0);
`endif

        // reset mid-frame
        for (int i = 0; i < 3; i++) bus(A_DATA, 32'($urandom_range(0, 255)), 1'b1, 4'b0001);
        idle(15);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("tx_at_reset", 32'(uart_tx), 32'h1);
        check("readdata_at_reset", ReadData, 32'h0);
        check("leds_at_reset", 32'(leds), 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        led_m = 8'h00;
        bus(A_STAT, 32'h0, 1'b0, 4'h0);
        check("status_after_midreset", ReadData, 32'h0);
        bus(A_CYC, 32'h0, 1'b0, 4'h0);
        check("cycle_restart", ReadData, 32'(tb_cyc - 1));
        check("cycle_restart_small", 32'(ReadData < 32'd8), 32'h1);
        cnt = 0;
        for (int k = 0; k < 2 * FRAME; k++) begin
            idle(1);
            if (uart_tx !== 1'b1) cnt++;
        end
        check("tx_idle_after_reset", 32'(cnt), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
